// File: rtl/cic_ctrl_pkg.sv
// rtl/cic_ctrl_pkg.sv - shared state encoding, rate limits and clamp for the CIC sequencer
// Also imported by the register-bank decoder so both agree on legal rates.
package cic_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } cic_state_e;

  localparam logic [7:0] RATE_MIN = 8'd1;
  localparam logic [7:0] RATE_MAX = 8'd127;

  function automatic logic [7:0] clamp_rate(input logic [7:0] rate);
    logic [7:0] r;
    r = rate;
    if (rate < RATE_MIN) r = RATE_MIN;
    if (rate > RATE_MAX) r = RATE_MAX;
    return r;
  endfunction

endpackage

// File: rtl/cic_strobe_count.sv
// rtl/cic_strobe_count.sv - 7-bit input-strobe counter with clear, terminal compare and wrap
// hit_o is combinational so the decimated strobe lands on the same clock as the last input strobe.
module cic_strobe_count (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear_i,
  input  logic       inc_i,
  input  logic [6:0] terminal_i,
  output logic       hit_o
);

  logic [6:0] count_q;
  logic [6:0] count_d;

  assign hit_o = inc_i && (count_q == terminal_i);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 7'd0;
    end else if (inc_i) begin
      count_d = hit_o ? 7'd0 : count_q + 7'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 7'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// rtl/cic_decim_ctrl.sv - reset/enable/rate/strobe sequencer for one cic_decim instance
// Flushes the CIC on enable or rate change and hides output until its history is clean.
module cic_decim_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int N            = 4,
  parameter int SETTLE_EXTRA = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable_in,
  input  logic [7:0] rate_in,
  input  logic       strobe_in,
  output logic       cic_reset,
  output logic       cic_enable,
  output logic [7:0] cic_rate,
  output logic       cic_strobe_in,
  output logic       cic_strobe_out,
  output logic       out_valid,
  output logic       busy
);

  localparam int SETTLE_LEN = N + SETTLE_EXTRA;
  localparam int SW = $clog2(SETTLE_LEN + 1);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  cic_state_e    state_q, state_d;
  logic [7:0]    rate_q, rate_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic          valid1_q, valid1_d;
  logic          valid2_q, valid2_d;

  logic [7:0]    rate_clamped;
  logic          active;
  logic          rate_change;
  logic          drop;
  logic          hit;

  assign rate_clamped = clamp_rate(rate_in);
  assign active       = (state_q == ST_SETTLE) || (state_q == ST_RUN);
  assign rate_change  = active && (rate_clamped != rate_q);
  // Anything that leaves SETTLE/RUN this clock discards the pending strobe.
  assign drop         = active && (rate_change || !enable_in);

  assign cic_reset      = !active;
  assign cic_enable     = active;
  assign cic_rate       = rate_q;
  assign cic_strobe_in  = strobe_in && active && !drop;
  assign cic_strobe_out = hit;
  assign out_valid      = valid2_q;
  assign busy           = (state_q != ST_RUN);

  cic_strobe_count u_strobe_count (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear_i    (!active),
    .inc_i      (cic_strobe_in),
    .terminal_i (rate_q[6:0]),
    .hit_o      (hit)
  );

  always_comb begin
    state_d      = state_q;
    rate_d       = rate_q;
    flush_cnt_d  = flush_cnt_q;
    settle_cnt_d = settle_cnt_q;
    if (!enable_in) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end
        ST_FLUSH: begin
          rate_d       = rate_clamped;
          settle_cnt_d = '0;
          if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) begin
            state_d = ST_SETTLE;
          end else begin
            flush_cnt_d = flush_cnt_q + FW'(1);
          end
        end
        ST_SETTLE: begin
          if (rate_change) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
          end else if (hit) begin
            settle_cnt_d = settle_cnt_q + SW'(1);
            if (settle_cnt_q == SW'(SETTLE_LEN - 1)) begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (rate_change) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Two stages: CIC pipeline update, then CIC output register.
  always_comb begin
    valid1_d = hit && (state_q == ST_RUN);
    valid2_d = drop ? 1'b0 : valid1_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rate_q       <= RATE_MIN;
      flush_cnt_q  <= '0;
      settle_cnt_q <= '0;
      valid1_q     <= 1'b0;
      valid2_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rate_q       <= rate_d;
      flush_cnt_q  <= flush_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      valid1_q     <= valid1_d;
      valid2_q     <= valid2_d;
    end
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb/tb_cic_decim_ctrl.sv - directed self-checking bench for cic_decim_ctrl
module tb_cic_decim_ctrl;

  localparam int SUPPRESSED = 6;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable_in;
  logic [7:0] rate_in;
  logic       strobe_in;
  logic       cic_reset;
  logic       cic_enable;
  logic [7:0] cic_rate;
  logic       cic_strobe_in;
  logic       cic_strobe_out;
  logic       out_valid;
  logic       busy;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  cic_decim_ctrl #(.N(4), .SETTLE_EXTRA(2), .FLUSH_CYCLES(2)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable_in      (enable_in),
    .rate_in        (rate_in),
    .strobe_in      (strobe_in),
    .cic_reset      (cic_reset),
    .cic_enable     (cic_enable),
    .cic_rate       (cic_rate),
    .cic_strobe_in  (cic_strobe_in),
    .cic_strobe_out (cic_strobe_out),
    .out_valid      (out_valid),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic flush_seq;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check("flush_reset",  32'(cic_reset), 1);
      check("flush_enable", 32'(cic_enable), 0);
      check("flush_busy",   32'(busy), 1);
      check("flush_sout",   32'(cic_strobe_out), 0);
      check("flush_valid",  32'(out_valid), 0);
      next_cycle();
    end
  endtask

  // Entered at the first SETTLE cycle with strobe_in held high every clock.
  task automatic run_phase(input int ncyc, input int rate);
    int p;
    p = rate + 1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      if (i == 0) begin
        check("settle_reset",  32'(cic_reset), 0);
        check("settle_enable", 32'(cic_enable), 1);
        check("settle_rate",   32'(cic_rate), 32'(rate));
      end
      check("run_sout",  32'(cic_strobe_out), 32'((i % p) == (p - 1)));
      check("run_valid", 32'(out_valid),
            32'((i >= 2) && (((i - 2) % p) == (p - 1)) && (((i - 2) / p) >= SUPPRESSED)));
      check("run_busy",  32'(busy), 32'(i < SUPPRESSED * p));
      next_cycle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    enable_in = 1'b0;
    rate_in   = 8'd3;
    strobe_in = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_reset",  32'(cic_reset), 1);
    check("rst_enable", 32'(cic_enable), 0);
    check("rst_rate",   32'(cic_rate), 1);
    check("rst_sin",    32'(cic_strobe_in), 0);
    check("rst_sout",   32'(cic_strobe_out), 0);
    check("rst_valid",  32'(out_valid), 0);
    check("rst_busy",   32'(busy), 1);
    @(posedge clock);
    #1 reset_n = 1'b1;

    repeat (3) begin
      @(negedge clock);
      check("idle_reset", 32'(cic_reset), 1);
      check("idle_sin",   32'(cic_strobe_in), 0);
      check("idle_busy",  32'(busy), 1);
      next_cycle();
    end

    enable_in = 1'b1;
    @(negedge clock);
    check("en_idle_reset", 32'(cic_reset), 1);
    next_cycle();
    flush_seq();
    run_phase(42, 3);

    rate_in = 8'd15;
    @(negedge clock);
    check("chg_sin",  32'(cic_strobe_in), 0);
    check("chg_busy", 32'(busy), 0);
    next_cycle();
    flush_seq();
    run_phase(127, 15);

    rate_in = 8'd0;
    @(negedge clock);
    check("coll_sout", 32'(cic_strobe_out), 0);
    check("coll_sin",  32'(cic_strobe_in), 0);
    next_cycle();
    flush_seq();
    run_phase(20, 1);

    strobe_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("gap_sout",  32'(cic_strobe_out), 0);
      check("gap_valid", 32'(out_valid), 32'(k == 1));
      check("gap_busy",  32'(busy), 0);
      next_cycle();
    end

    strobe_in = 1'b1;
    rate_in   = 8'd200;
    @(negedge clock);
    check("clamp_chg_busy", 32'(busy), 0);
    next_cycle();
    flush_seq();
    run_phase(3, 127);

    enable_in = 1'b0;
    @(negedge clock);
    check("abort_enable", 32'(cic_enable), 1);
    check("abort_sin",    32'(cic_strobe_in), 0);
    next_cycle();
    @(negedge clock);
    check("abort_reset",  32'(cic_reset), 1);
    check("abort_en_off", 32'(cic_enable), 0);
    check("abort_busy",   32'(busy), 1);
    next_cycle();

    rate_in   = 8'd0;
    enable_in = 1'b1;
    @(negedge clock);
    check("re_idle_reset", 32'(cic_reset), 1);
    next_cycle();
    flush_seq();
    run_phase(14, 1);

    reset_n = 1'b0;
    #1;
    check("arst_reset", 32'(cic_reset), 1);
    check("arst_busy",  32'(busy), 1);
    check("arst_rate",  32'(cic_rate), 1);
    check("arst_valid", 32'(out_valid), 0);
    #1 reset_n = 1'b1;
    next_cycle();
    @(negedge clock);
    check("arst_inflight", 32'(out_valid), 0);
    next_cycle();
    @(negedge clock);
    check("arst_valid_late", 32'(out_valid), 0);
    check("arst_flush",      32'(cic_reset), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
